// File: rtl/axis_differentiator_seq.sv
// Mode sequencer for the streaming differentiator: clears datapath history, masks warm-up
// beats and only switches between bypass and differentiate on beat-free cycles.
module axis_differentiator_seq #(
    parameter int unsigned WARMUP    = 6,
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 enable_req,
    input  logic                 S_AXIS_tvalid,
    output logic                 dp_enable,
    output logic                 dp_aresetn,
    output logic                 out_valid_mask,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] sample_count
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StClear  = 2'd1,
        StWarmup = 2'd2,
        StRun    = 2'd3
    } state_e;

    localparam logic [7:0]           WarmupTarget = 8'(WARMUP);
    localparam logic [CNT_WIDTH-1:0] CntMax       = '1;

    state_e                 state_q;
    logic [7:0]             warm_cnt_q;
    logic [CNT_WIDTH-1:0]   sample_count_q;
    logic                   dp_enable_q;
    logic                   dp_aresetn_q;
    logic                   mask_q;

    // Outputs are registered alongside the state so each one matches the state being entered.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q        <= StIdle;
            warm_cnt_q     <= 8'd0;
            sample_count_q <= '0;
            dp_enable_q    <= 1'b0;
            dp_aresetn_q   <= 1'b1;
            mask_q         <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (enable_req && !S_AXIS_tvalid) begin
                        state_q        <= StClear;
                        warm_cnt_q     <= 8'd0;
                        sample_count_q <= '0;
                        dp_enable_q    <= 1'b1;
                        dp_aresetn_q   <= 1'b0;
                        mask_q         <= 1'b0;
                    end
                end
                StClear: begin
                    // A beat seen here is deliberately dropped from the warm-up count.
                    state_q      <= StWarmup;
                    dp_enable_q  <= 1'b1;
                    dp_aresetn_q <= 1'b1;
                    mask_q       <= 1'b0;
                end
                StWarmup: begin
                    if (S_AXIS_tvalid) begin
                        warm_cnt_q <= warm_cnt_q + 8'd1;
                        if (warm_cnt_q + 8'd1 == WarmupTarget) begin
                            state_q <= StRun;
                            mask_q  <= 1'b1;
                        end
                    end else if (!enable_req) begin
                        state_q     <= StIdle;
                        dp_enable_q <= 1'b0;
                        mask_q      <= 1'b1;
                    end
                end
                StRun: begin
                    if (S_AXIS_tvalid) begin
                        if (sample_count_q != CntMax) begin
                            sample_count_q <= sample_count_q + 1'b1;
                        end
                    end else if (!enable_req) begin
                        state_q     <= StIdle;
                        dp_enable_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign dp_enable      = dp_enable_q;
    assign dp_aresetn     = dp_aresetn_q;
    assign out_valid_mask = mask_q;
    assign state          = state_q;
    assign sample_count   = sample_count_q;

endmodule

// File: tb/tb_axis_differentiator_seq.sv
// Directed bench for axis_differentiator_seq: default instance plus a 4-bit counter instance
// driven by the same stimulus to observe saturation.
module tb_axis_differentiator_seq;

    logic        aclk = 1'b0;
    logic        areset;
    logic        enable_req;
    logic        s_tvalid;
    logic        dp_enable, dp_aresetn, out_valid_mask;
    logic [1:0]  state;
    logic [31:0] sample_count;
    logic        sat_dp_enable, sat_dp_aresetn, sat_mask;
    logic [1:0]  sat_state;
    logic [3:0]  sat_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 aclk = ~aclk;

    axis_differentiator_seq #(.WARMUP(6), .CNT_WIDTH(32)) u_dut (
        .aclk           (aclk),
        .areset         (areset),
        .enable_req     (enable_req),
        .S_AXIS_tvalid  (s_tvalid),
        .dp_enable      (dp_enable),
        .dp_aresetn     (dp_aresetn),
        .out_valid_mask (out_valid_mask),
        .state          (state),
        .sample_count   (sample_count)
    );

    axis_differentiator_seq #(.WARMUP(6), .CNT_WIDTH(4)) u_sat (
        .aclk           (aclk),
        .areset         (areset),
        .enable_req     (enable_req),
        .S_AXIS_tvalid  (s_tvalid),
        .dp_enable      (sat_dp_enable),
        .dp_aresetn     (sat_dp_aresetn),
        .out_valid_mask (sat_mask),
        .state          (sat_state),
        .sample_count   (sat_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // State plus the three control outputs of the main instance.
    task automatic check_st(input string tag, input logic [1:0] st, input logic en,
                            input logic rn, input logic mk);
        check_eq({tag, ".state"}, 32'(state), 32'(st));
        check_eq({tag, ".dp_enable"}, 32'(dp_enable), 32'(en));
        check_eq({tag, ".dp_aresetn"}, 32'(dp_aresetn), 32'(rn));
        check_eq({tag, ".mask"}, 32'(out_valid_mask), 32'(mk));
    endtask

    task automatic step(input logic en, input logic v);
        enable_req = en;
        s_tvalid   = v;
        @(posedge aclk);
        #1;
    endtask

    initial begin
        areset     = 1'b1;
        enable_req = 1'b0;
        s_tvalid   = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        check_st("reset", 2'd0, 1'b0, 1'b1, 1'b1);
        check_eq("reset.count", sample_count, 32'd0);
        areset = 1'b0;

        // Clean enable, beats every second cycle.
        step(1'b1, 1'b0);
        check_st("en.clear", 2'd1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0);
        check_st("en.warm", 2'd2, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 1'b1);
            if (i < 6) check_st("en.warm_beat", 2'd2, 1'b1, 1'b1, 1'b0);
            else       check_st("en.run", 2'd3, 1'b1, 1'b1, 1'b1);
            step(1'b1, 1'b0);
        end
        check_eq("en.run_count0", sample_count, 32'd0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1);
            step(1'b1, 1'b0);
        end
        check_eq("en.count10", sample_count, 32'd10);
        check_eq("en.sat_count10", 32'(sat_count), 32'd10);
        step(1'b0, 1'b1);
        check_st("dis.blocked", 2'd3, 1'b1, 1'b1, 1'b1);
        check_eq("dis.blocked_count", sample_count, 32'd11);
        step(1'b0, 1'b0);
        check_st("dis.idle", 2'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0);
        check_eq("dis.count_hold", sample_count, 32'd11);

        // Gated enable: beats held high keep the block in bypass.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1);
            check_st("gate.idle", 2'd0, 1'b0, 1'b1, 1'b1);
        end
        step(1'b1, 1'b0);
        check_st("gate.clear", 2'd1, 1'b1, 1'b0, 1'b0);
        check_eq("gate.count_clr", sample_count, 32'd0);

        // Beat on the CLEAR cycle is dropped; six more back-to-back beats needed.
        step(1'b1, 1'b1);
        check_st("clrbeat.warm", 2'd2, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b1);
        check_st("clrbeat.still_warm", 2'd2, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1);
        check_st("clrbeat.run", 2'd3, 1'b1, 1'b1, 1'b1);

        // Saturation of the 4-bit instance.
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1);
        check_eq("sat.at15", 32'(sat_count), 32'd15);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
        check_eq("sat.hold15", 32'(sat_count), 32'd15);
        check_eq("sat.wide20", sample_count, 32'd20);
        step(1'b0, 1'b0);
        check_eq("sat.idle_state", 32'(sat_state), 32'd0);
        check_eq("sat.idle_hold", 32'(sat_count), 32'd15);
        step(1'b1, 1'b0);
        check_eq("sat.clear_state", 32'(sat_state), 32'd1);
        check_eq("sat.clear_count", 32'(sat_count), 32'd0);
        check_eq("sat.clear_wide", sample_count, 32'd0);

        // Abort in WARMUP after two beats, then re-enable restarts the warm-up count.
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        check_st("abort.beat_blocks", 2'd2, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0);
        check_st("abort.idle", 2'd0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0);
        check_st("abort.reclear", 2'd1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) step(1'b1, 1'b1);
        check_st("abort.restart_warm", 2'd2, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1);
        check_st("abort.run", 2'd3, 1'b1, 1'b1, 1'b1);

        // Asynchronous reset mid-WARMUP (count 3).
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        check_st("rst.pre_warm", 2'd2, 1'b1, 1'b1, 1'b0);
        #2 areset = 1'b1;
        #1;
        check_st("rst.async", 2'd0, 1'b0, 1'b1, 1'b1);
        check_eq("rst.count", sample_count, 32'd0);
        areset = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        check_st("rst.stay_idle", 2'd0, 1'b0, 1'b1, 1'b1);

        // Reset during CLEAR releases the datapath clear.
        step(1'b1, 1'b0);
        check_st("rst2.clear", 2'd1, 1'b1, 1'b0, 1'b0);
        #2 areset = 1'b1;
        #1;
        check_st("rst2.async", 2'd0, 1'b0, 1'b1, 1'b1);
        areset = 1'b0;
        step(1'b0, 1'b0);
        check_st("rst2.idle", 2'd0, 1'b0, 1'b1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axis_differentiator_seq.md
# axis_differentiator_seq

Mode sequencer for the streaming differentiator in the vibrometer signal chain. It turns a software enable request into a clean mode change. The datapath's sample history is cleared, the first `WARMUP` beats after enabling are masked, and switches between bypass and differentiate happen only between beats. The block is control-only: it never touches tdata. It drives the datapath's enable and synchronous reset, plus a valid mask that the top level ANDs into `M_AXIS_tvalid`.

## Interface
- `WARMUP`, default 6: number of input beats suppressed after a clear (5-deep history plus result register); legal range 1..255.
- `CNT_WIDTH`, default 32: width of the processed-sample counter.

- `aclk`  in  1  system clock; all logic is on the rising edge.
- `areset`  in  1  asynchronous, active-high reset; it forces all state to reset values immediately.
- `enable_req`  in  1  differentiate request from the register bank; synchronous to `aclk`; level-sensitive.
- `S_AXIS_tvalid`  in  1  beat strobe, the same signal that feeds the datapath.
- `dp_enable`  out  1  datapath enable (1 = differentiate, 0 = bypass).
- `dp_aresetn`  out  1  active-low synchronous clear for the datapath history.
- `out_valid_mask`  out  1  1 = downstream tvalid may pass; 0 = suppress.
- `state`  out  2  current state, encoded IDLE=0, CLEAR=1, WARMUP=2, RUN=3.
- `sample_count`  out  CNT_WIDTH  beats delivered in RUN since the last clear.

## Operation
- This is a Moore FSM. Every output is decoded from registered state or counters; there is no combinational path from input to output.
- **IDLE** (bypass)
  - Outputs: `dp_enable`=0, `dp_aresetn`=1, `out_valid_mask`=1.
  - Go to CLEAR when `enable_req`=1 and `S_AXIS_tvalid`=0.
  - If `enable_req`=1 while `S_AXIS_tvalid`=1, stay in IDLE. Re-evaluate every cycle until a cycle with no beat.
- **CLEAR**
  - Lasts exactly one cycle.
  - Outputs: `dp_enable`=1, `dp_aresetn`=0, `out_valid_mask`=0.
  - On entry: warm-up counter cleared to 0, `sample_count` cleared to 0.
  - A beat arriving during CLEAR is lost: it is masked and not counted toward WARMUP.
  - Always go to WARMUP next, regardless of `enable_req`.
- **WARMUP**
  - Outputs: `dp_enable`=1, `dp_aresetn`=1, `out_valid_mask`=0.
  - The warm-up counter increments on each cycle with `S_AXIS_tvalid`=1.
  - Go to RUN on the beat that brings the count to `WARMUP`.
  - If `enable_req`=0 on a cycle with `S_AXIS_tvalid`=0, go to IDLE. This takes priority over reaching the count, which cannot happen on a no-beat cycle anyway.
- **RUN**
  - Outputs: `dp_enable`=1, `dp_aresetn`=1, `out_valid_mask`=1.
  - `sample_count` increments on each beat and saturates at all-ones (no wrap).
  - Go to IDLE when `enable_req`=0 and `S_AXIS_tvalid`=0.
- `sample_count` holds its value in IDLE. It is cleared only by `areset` or on entry to CLEAR.
- A re-enable from IDLE always passes through CLEAR. History is never reused.
- An `enable_req` pulse shorter than one beat gap may be missed in IDLE. This is acceptable because the register bank holds levels.

## Timing
- Reset values: `state`=IDLE, `dp_enable`=0, `dp_aresetn`=1, `out_valid_mask`=1, `sample_count`=0, warm-up counter 0.
- `areset` asserted in any state returns the block to IDLE asynchronously. If `dp_aresetn` was low in CLEAR, it returns high.
- Enable latency: `enable_req` rises at edge t with no beat. The block is in CLEAR at t+1 and in WARMUP at t+2.
- RUN entry: reached on the edge after the `WARMUP`-th beat counted in WARMUP. The mask is 1 from that cycle on.
- Disable latency: in RUN, the first no-beat cycle with `enable_req`=0 moves the block to IDLE on the next edge. No beat is ever split between modes.
- Back-to-back beats (`S_AXIS_tvalid` held at 1) block every mode change except CLEAR→WARMUP and WARMUP→RUN.
- Counter width: the warm-up counter is 8 bits; `sample_count` is `CNT_WIDTH` bits and saturating.

## Test plan
- **Reset:** assert `areset` mid-WARMUP (count=3) → the block is in IDLE immediately with `dp_enable`=0, mask=1, `sample_count`=0. After release it stays in IDLE with `enable_req`=0.
- **Clean enable:** `WARMUP`=6, `enable_req`=1 while idle, then beats every 2nd cycle → one cycle of CLEAR with `dp_aresetn`=0, mask=0 for exactly 6 beats, RUN after the 6th, then `sample_count` reaches 10 after 10 more beats.
- **Gated enable:** `enable_req` rises while `S_AXIS_tvalid` is held at 1 for 8 cycles → the block stays in IDLE with mask=1 for all 8 beats. It enters CLEAR on the first no-beat cycle.
- **Beat in CLEAR:** a beat on the CLEAR cycle → not counted. RUN entry still requires 6 further beats.
- **Abort in WARMUP:** `enable_req` drops after 2 warm-up beats, with gap cycles present → IDLE on the next no-beat edge with mask=1. Re-enabling passes through CLEAR again and the warm-up count restarts at 0.
- **Saturation:** `CNT_WIDTH`=4 in RUN, 20 beats → `sample_count` holds at 15. Disable then re-enable → the count clears to 0 on the CLEAR cycle.
